// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle processor control FSM: state
// encoding, opcode constants, ALU operation encodings and opcode dispatch.
package multicycle_control_pkg;

   // Controller states; 4 bits leave room for the 12 states in use.
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      WB_ALU   = 4'd7,
      WB_MEM   = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   // Supported instruction opcodes (instruction bits [6:0]).
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALU operation requests handed to the ALU control unit.
   localparam logic [1:0] ALUOP_MEM    = 2'b00;  // address add
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;  // decode funct fields

   // State entered from DECODE for a given opcode; anything unknown traps.
   function automatic state_t dispatch(input logic [6:0] opcode);
      state_t target;
      case (opcode)
         OP_RTYPE:           target = EXEC_R;
         OP_ITYPE:           target = EXEC_I;
         OP_LOAD, OP_STORE:  target = MEM_ADDR;
         OP_BRANCH:          target = BRANCH;
         OP_JAL:             target = JAL;
         default:            target = TRAP;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a Moore FSM sequencing fetch, decode,
// execute, memory and write-back steps, plus a retired-instruction counter.
// Only ir_write/pc_write in FETCH look at mem_ready combinationally.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        pc_src,
   output logic        iord,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [31:0] instret
);

   state_t      state;
   state_t      state_next;
   logic        retire;
   logic [31:0] instret_q;

   // State register; synchronous reset wins over every transition.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values, whatever order blocks evaluate in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Retired-instruction counter; wraps silently at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;

   // Next-state logic; mem_ready is only consulted by the memory-access states.
   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         FETCH:    if (mem_ready) state_next = DECODE;
         DECODE:   state_next = dispatch(opcode);
         EXEC_R:   state_next = WB_ALU;
         EXEC_I:   state_next = WB_ALU;
         MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready) state_next = WB_MEM;
         MEM_WR:   if (mem_ready) state_next = FETCH;
         WB_ALU:   state_next = FETCH;
         WB_MEM:   state_next = FETCH;
         BRANCH:   state_next = FETCH;
         JAL:      state_next = FETCH;
         TRAP:     state_next = TRAP;
         default:  state_next = FETCH;
      endcase
   end

   // An instruction retires on every transition back into FETCH; only the
   // final step of an instruction ever returns there.
   always_comb begin
      retire = (state != FETCH) && (state_next == FETCH);
   end

   // Output decode: Moore outputs per state, all forced low during reset.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      iord          = 1'b0;
      alu_src_b     = 1'b0;
      alu_op        = ALUOP_MEM;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      illegal       = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_read = 1'b1;
               // Instruction register and PC load only when the fetch lands.
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            EXEC_R: begin
               alu_op = ALUOP_FUNCT;
            end
            EXEC_I: begin
               alu_op    = ALUOP_FUNCT;
               alu_src_b = 1'b1;
            end
            MEM_ADDR: begin
               alu_src_b = 1'b1;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            WB_ALU: begin
               reg_write = 1'b1;
            end
            WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            BRANCH: begin
               alu_op        = ALUOP_BRANCH;
               pc_write_cond = 1'b1;
            end
            JAL: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               pc_src    = 1'b1;
            end
            TRAP: begin
               // TRAP never exits, so this flag stays set until reset.
               illegal = 1'b1;
            end
            default: begin
               // DECODE and unused encodings drive nothing.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a table of single-instruction
// latency vectors, hand sequences for the multi-cycle corner cases, and a
// randomized run against an instruction-recipe reference model.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src;
   logic        iord, alu_src_b, reg_write, mem_to_reg, illegal;
   logic [1:0]  alu_op;
   logic [31:0] instret;

   multicycle_control dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .iord          (iord),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .illegal       (illegal),
      .instret       (instret)
   );

   always #5 clk = ~clk;

   // Bundle of every control output, compared as one vector.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic       iord;
      logic       alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       illegal;
   } ctrl_t;

   // One step of an instruction recipe in the reference model.
   typedef struct {
      ctrl_t c;
      bit    waits;   // held until mem_ready=1
      bit    fetch;   // ir_write/pc_write follow mem_ready
      bit    retire;  // leaving this step retires the instruction
   } step_t;

   // Latency vector: opcode, wait cycles in fetch and data access, expected cycles.
   typedef struct {
      logic [6:0] op;
      int         fw;
      int         mw;
      int         cycles;
   } lat_vec_t;

   int n_checks = 0;
   int n_errors = 0;

   ctrl_t c_zero, c_fetch, c_fetch_go, c_decode, c_exec_r, c_exec_i, c_mem_addr;
   ctrl_t c_mem_rd, c_mem_wr, c_wb_alu, c_wb_mem, c_branch, c_jal, c_trap;

   step_t       model_q[$];
   logic [31:0] model_instret;

   function automatic ctrl_t get_ctrl();
      ctrl_t c;
      c.mem_read      = mem_read;
      c.mem_write     = mem_write;
      c.ir_write      = ir_write;
      c.pc_write      = pc_write;
      c.pc_write_cond = pc_write_cond;
      c.pc_src        = pc_src;
      c.iord          = iord;
      c.alu_src_b     = alu_src_b;
      c.alu_op        = alu_op;
      c.reg_write     = reg_write;
      c.mem_to_reg    = mem_to_reg;
      c.illegal       = illegal;
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic init_consts();
      c_zero = '0;
      c_fetch = '0;  c_fetch.mem_read = 1'b1;
      c_fetch_go = c_fetch;  c_fetch_go.ir_write = 1'b1;  c_fetch_go.pc_write = 1'b1;
      c_decode = '0;
      c_exec_r = '0;  c_exec_r.alu_op = 2'b10;
      c_exec_i = '0;  c_exec_i.alu_op = 2'b10;  c_exec_i.alu_src_b = 1'b1;
      c_mem_addr = '0;  c_mem_addr.alu_src_b = 1'b1;
      c_mem_rd = '0;  c_mem_rd.mem_read = 1'b1;  c_mem_rd.iord = 1'b1;
      c_mem_wr = '0;  c_mem_wr.mem_write = 1'b1;  c_mem_wr.iord = 1'b1;
      c_wb_alu = '0;  c_wb_alu.reg_write = 1'b1;
      c_wb_mem = '0;  c_wb_mem.reg_write = 1'b1;  c_wb_mem.mem_to_reg = 1'b1;
      c_branch = '0;  c_branch.alu_op = 2'b01;  c_branch.pc_write_cond = 1'b1;
      c_jal = '0;  c_jal.reg_write = 1'b1;  c_jal.pc_write = 1'b1;  c_jal.pc_src = 1'b1;
      c_trap = '0;  c_trap.illegal = 1'b1;
   endtask

   // All tasks below start just after a falling edge and end on the next one.

   // One cycle: drive mem_ready, compare outputs and instret, advance a clock.
   task automatic step(input string name, input logic mr, input ctrl_t exp_c,
                       input logic [31:0] exp_ir);
      mem_ready = mr;
      #1;
      check({name, "_ctrl"}, 32'(get_ctrl()), 32'(exp_c));
      check({name, "_instret"}, instret, exp_ir);
      @(posedge clk);
      @(negedge clk);
   endtask

   // One reset cycle; outputs must be all low while reset is high.
   task automatic do_reset(input logic mr);
      reset     = 1'b1;
      mem_ready = mr;
      #1;
      check("reset_outputs", 32'(get_ctrl()), 32'(c_zero));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Run one instruction from FETCH, stalling memory as asked; returns the
   // cycle count until instret moves, or -1 if it never does.
   task automatic run_count(input logic [6:0] op, input int fw, input int mw,
                            output int cycles);
      logic [31:0] start_ir;
      int fcnt;
      int dcnt;
      start_ir = instret;
      opcode   = op;
      fcnt     = 0;
      dcnt     = 0;
      cycles   = -1;
      for (int n = 1; n <= 60; n++) begin
         if (mem_read && !iord && fcnt < fw) begin
            mem_ready = 1'b0;
            fcnt++;
         end else if (iord && dcnt < mw) begin
            mem_ready = 1'b0;
            dcnt++;
         end else begin
            mem_ready = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         if (instret != start_ir) begin
            cycles = n;
            break;
         end
      end
   endtask

   // Reference model: expand an opcode into its sequence of control steps.
   task automatic push_step(input ctrl_t c, input bit waits, input bit fetch, input bit retire);
      step_t s;
      s.c = c;  s.waits = waits;  s.fetch = fetch;  s.retire = retire;
      model_q.push_back(s);
   endtask

   task automatic push_instr(input logic [6:0] op);
      push_step(c_fetch, 1, 1, 0);
      push_step(c_decode, 0, 0, 0);
      case (op)
         7'b0110011: begin push_step(c_exec_r, 0, 0, 0); push_step(c_wb_alu, 0, 0, 1); end
         7'b0010011: begin push_step(c_exec_i, 0, 0, 0); push_step(c_wb_alu, 0, 0, 1); end
         7'b0000011: begin
            push_step(c_mem_addr, 0, 0, 0);
            push_step(c_mem_rd, 1, 0, 0);
            push_step(c_wb_mem, 0, 0, 1);
         end
         7'b0100011: begin push_step(c_mem_addr, 0, 0, 0); push_step(c_mem_wr, 1, 0, 1); end
         7'b1100011: push_step(c_branch, 0, 0, 1);
         7'b1101111: push_step(c_jal, 0, 0, 1);
         default:    push_step(c_trap, 0, 0, 0);
      endcase
   endtask

   lat_vec_t   lat_tab[12];
   logic [6:0] legal_ops[6];

   initial begin
      int cyc;
      init_consts();
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
      lat_tab[0]  = '{7'b0110011, 0, 0, 4};
      lat_tab[1]  = '{7'b0010011, 0, 0, 4};
      lat_tab[2]  = '{7'b0000011, 0, 0, 5};
      lat_tab[3]  = '{7'b0100011, 0, 0, 4};
      lat_tab[4]  = '{7'b1100011, 0, 0, 3};
      lat_tab[5]  = '{7'b1101111, 0, 0, 3};
      lat_tab[6]  = '{7'b0110011, 2, 0, 6};
      lat_tab[7]  = '{7'b0000011, 1, 2, 8};
      lat_tab[8]  = '{7'b0100011, 0, 3, 7};
      lat_tab[9]  = '{7'b1100011, 3, 0, 6};
      lat_tab[10] = '{7'b1101111, 0, 3, 3};
      lat_tab[11] = '{7'b0010011, 1, 0, 5};

      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 7'b0110011;
      @(negedge clk);
      do_reset(1'b0);
      step("reset_state", 1'b0, c_fetch, 32'd0);

      // Latency table, one instruction per entry, back to back.
      for (int i = 0; i < 12; i++) begin
         run_count(lat_tab[i].op, lat_tab[i].fw, lat_tab[i].mw, cyc);
         check($sformatf("latency_%0d", i), 32'(cyc), 32'(lat_tab[i].cycles));
      end
      check("latency_instret", instret, 32'd12);

      // R-type with zero-wait memory.
      do_reset(1'b1);
      opcode = 7'b0110011;
      step("r_fetch", 1'b1, c_fetch_go, 32'd0);
      step("r_decode", 1'b1, c_decode, 32'd0);
      step("r_exec", 1'b1, c_exec_r, 32'd0);
      step("r_wb", 1'b1, c_wb_alu, 32'd0);
      step("r_next", 1'b0, c_fetch, 32'd1);

      // Load: two fetch waits, three read waits -> ten cycles.
      do_reset(1'b0);
      opcode = 7'b0000011;
      step("ld_fwait0", 1'b0, c_fetch, 32'd0);
      step("ld_fwait1", 1'b0, c_fetch, 32'd0);
      step("ld_fetch", 1'b1, c_fetch_go, 32'd0);
      step("ld_decode", 1'b1, c_decode, 32'd0);
      step("ld_addr", 1'b0, c_mem_addr, 32'd0);
      for (int k = 0; k < 3; k++) step("ld_rwait", 1'b0, c_mem_rd, 32'd0);
      step("ld_read", 1'b1, c_mem_rd, 32'd0);
      step("ld_wb", 1'b0, c_wb_mem, 32'd0);
      step("ld_next", 1'b0, c_fetch, 32'd1);

      // Store: MEM_WR holds until mem_ready, retiring on the way to FETCH.
      do_reset(1'b0);
      opcode = 7'b0100011;
      step("st_fetch", 1'b1, c_fetch_go, 32'd0);
      step("st_decode", 1'b0, c_decode, 32'd0);
      step("st_addr", 1'b1, c_mem_addr, 32'd0);
      step("st_wwait0", 1'b0, c_mem_wr, 32'd0);
      step("st_wwait1", 1'b0, c_mem_wr, 32'd0);
      step("st_write", 1'b1, c_mem_wr, 32'd0);
      step("st_next", 1'b0, c_fetch, 32'd1);

      // Unsupported opcode: TRAP is absorbing until reset.
      do_reset(1'b0);
      opcode = 7'b1110011;
      step("trap_fetch", 1'b1, c_fetch_go, 32'd0);
      step("trap_decode", 1'b1, c_decode, 32'd0);
      for (int k = 0; k < 20; k++) step("trap_hold", 1'($urandom_range(0, 1)), c_trap, 32'd0);
      do_reset(1'b1);
      step("trap_cleared", 1'b0, c_fetch, 32'd0);

      // instret wrap: preset near the top, then retire two branches.
      do_reset(1'b0);
      force dut.instret_q = 32'hFFFF_FFFE;
      #1;
      release dut.instret_q;
      opcode = 7'b1100011;
      step("wrap_fetch0", 1'b1, c_fetch_go, 32'hFFFF_FFFE);
      step("wrap_decode0", 1'b0, c_decode, 32'hFFFF_FFFE);
      step("wrap_branch0", 1'b0, c_branch, 32'hFFFF_FFFE);
      step("wrap_fetch1", 1'b1, c_fetch_go, 32'hFFFF_FFFF);
      step("wrap_decode1", 1'b1, c_decode, 32'hFFFF_FFFF);
      step("wrap_branch1", 1'b1, c_branch, 32'hFFFF_FFFF);
      step("wrap_zero", 1'b0, c_fetch, 32'd0);

      // Reset in MEM_RD while memory completes: no WB_MEM, back to FETCH.
      do_reset(1'b0);
      opcode = 7'b0000011;
      step("rr_fetch", 1'b1, c_fetch_go, 32'd0);
      step("rr_decode", 1'b1, c_decode, 32'd0);
      step("rr_addr", 1'b1, c_mem_addr, 32'd0);
      do_reset(1'b1);
      step("rr_after", 1'b0, c_fetch, 32'd0);

      // Randomized instruction stream against the recipe model.
      do_reset(1'b0);
      model_q.delete();
      model_instret = 32'd0;
      for (int n = 0; n < 400; n++) begin
         ctrl_t exp_c;
         if (model_q.size() == 0) begin
            opcode = legal_ops[$urandom_range(0, 5)];
            push_instr(opcode);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_c = model_q[0].c;
         if (model_q[0].fetch && mem_ready) begin
            exp_c.ir_write = 1'b1;
            exp_c.pc_write = 1'b1;
         end
         check("rand_ctrl", 32'(get_ctrl()), 32'(exp_c));
         check("rand_instret", instret, model_instret);
         if (!(model_q[0].waits && !mem_ready)) begin
            if (model_q[0].retire) model_instret = model_instret + 32'd1;
            void'(model_q.pop_front());
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
